tile_console_writer: RTL

- Character-stream front end that fills the tile-map RAM read by the tile renderer: drives the RAM write port (din/addr/we).
- Accepts printable characters plus a small set of control codes over a valid/ready handshake.
- Tracks a cursor and writes 16-bit tile cells {attr, char}.
- Defers every RAM write while the renderer holds ram_busy.

---
 rtl/tile_console_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tile_console_writer.sv
// Character-stream writer for the tile-map RAM: cursor tracking, control codes and a full-page clear.
// Optional build macro TILE_CONSOLE_CLEAR_ON_RESET_EN runs a clear with attr 8'h07 after every reset release.
module tile_console_writer #(
  parameter int          COLS      = 32,
  parameter int          ROWS      = 30,
  parameter int          ADDR_W    = 16,
  parameter int unsigned PAGE_BASE = 32'h7E00,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ch_valid,
  output logic                      ch_ready,
  input  logic [7:0]                ch_data,
  input  logic [7:0]                ch_attr,
  input  logic                      ram_busy,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [15:0]               ram_write,
  output logic                      ram_writeenable,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic                      busy
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = $clog2(COLS * ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         char_q, char_d;
  logic [7:0]         attr_q, attr_d;
  logic               idle_ready;
  logic               init_q;
  logic [ADDR_W-1:0]  cell_addr;

  // Cursor cell address; wraps modulo 2**ADDR_W by construction.
  assign cell_addr = ADDR_W'(PAGE_BASE) + ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

`ifdef TILE_CONSOLE_CLEAR_ON_RESET_EN
  // High only in the first cycle after reset release, kicking off the power-on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) init_q <= 1'b1;
    else        init_q <= 1'b0;
  end
`else
  assign init_q = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    idx_d           = idx_q;
    char_d          = char_q;
    attr_d          = attr_q;
    idle_ready      = 1'b0;
    ram_writeenable = 1'b0;
    ram_addr        = '0;
    ram_write       = '0;

    unique case (state_q)
      IDLE: begin
        if (init_q) begin
          state_d = CLEAR;
          idx_d   = '0;
          attr_d  = 8'h07;
        end else begin
          idle_ready = 1'b1;
          if (ch_valid && reset) begin
            char_d = ch_data;
            attr_d = ch_attr;
            unique case (ch_data)
              8'h08: begin
                if (col_q != '0) begin
                  col_d = col_q - 1'b1;
                end else if (row_q != '0) begin
                  col_d = COL_LAST;
                  row_d = row_q - 1'b1;
                end
              end
              8'h0A: begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
              end
              8'h0C: begin
                idx_d   = '0;
                state_d = CLEAR;
              end
              8'h0D:   col_d = '0;
              default: state_d = WRITE;
            endcase
          end
        end
      end

      WRITE: begin
        if (!ram_busy) begin
          ram_writeenable = 1'b1;
          ram_addr        = cell_addr;
          ram_write       = {attr_q, char_q};
          state_d         = IDLE;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      CLEAR: begin
        if (!ram_busy) begin
          ram_writeenable = 1'b1;
          ram_addr        = ADDR_W'(PAGE_BASE) + ADDR_W'(idx_q);
          ram_write       = {attr_q, FILL_CHAR};
          if (idx_q == IDX_LAST) begin
            col_d   = '0;
            row_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      attr_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      attr_q  <= attr_d;
    end
  end

  // Reset gates the handshake and busy flag so both read 0 while reset is held.
  assign ch_ready = idle_ready & reset;
  assign busy     = (state_q == CLEAR) | (init_q & reset);
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule
